// File: rtl/regfile_mp.sv
// Register file with two combinational read ports, one synchronous write port and a valid/ready dump engine.
// Define REGFILE_BYPASS_EN for write-first reads; the default build returns the stored (pre-write) value.
module regfile_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG    = 1,
    parameter int RESET_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              write_ok;

    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        if ((ZERO_REG != 0 && idx == 0) || RESET_INDEX == 0) begin
            return '0;
        end
        return DATA_W'(idx);
    endfunction

    // Entry 0 is never written when it is hardwired, so it keeps its zero reset value.
    assign write_ok = we && !(ZERO_REG != 0 && wa == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (write_ok) begin
            rf_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= reset_value(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    always_comb begin
        rd1 = rf_q[ra1];
`ifdef REGFILE_BYPASS_EN
        if (we && wa == ra1) begin
            rd1 = wd;
        end
`endif
        if (ZERO_REG != 0 && ra1 == '0) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = rf_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && wa == ra2) begin
            rd2 = wd;
        end
`endif
        if (ZERO_REG != 0 && ra2 == '0) begin
            rd2 = '0;
        end
    end

    // Captures sample rf_d so a write landing on the capturing edge is part of the word.
    always_comb begin
        state_d     = state_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = STREAM;
                    dump_idx_d  = '0;
                    dump_data_d = rf_d[0];
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (dump_idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        dump_idx_d  = '0;
                        dump_data_d = '0;
                    end else begin
                        dump_idx_d  = dump_idx_q + 1'b1;
                        dump_data_d = rf_d[dump_idx_q + 1'b1];
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                dump_idx_d  = '0;
                dump_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dump_idx_q  <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign dump_valid = (state_q == STREAM);
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_valid && (dump_idx_q == LAST_IDX);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bench-side register model predicts reads and every dump word.
// Build with REGFILE_BYPASS_EN defined to check the write-first read variant.
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } dumpWord_t;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] ra1, ra2, wa;
   logic [DATA_W-1:0] rd1, rd2, wd;
   logic              we, dump_start, dump_ready;
   logic              dump_valid, dump_last;
   logic [ADDR_W-1:0] dump_idx;
   logic [DATA_W-1:0] dump_data;

   dumpWord_t         expQueue[$];
   logic [DATA_W-1:0] model[DEPTH];
   int                checks;
   int                errors;
   int                wordCount;
   int                cycleCount;

   regfile_mp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .ZERO_REG(1),
      .RESET_INDEX(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ra1(ra1),
      .ra2(ra2),
      .rd1(rd1),
      .rd2(rd2),
      .we(we),
      .wa(wa),
      .wd(wd),
      .dump_start(dump_start),
      .dump_ready(dump_ready),
      .dump_valid(dump_valid),
      .dump_idx(dump_idx),
      .dump_data(dump_data),
      .dump_last(dump_last)
   );

   // Free-running clock; outputs are observed on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = DATA_W'(i);
      end
      model[0] = '0;
   endtask

   // Compares the presented dump word against the scoreboard head; pops it when accepted.
   task automatic observeDump(input logic readyV);
      dumpWord_t head;
      if (dump_valid) begin
         if (expQueue.size() == 0) begin
            checkOutput("dump_extra_word", 64'(dump_idx), 64'hFFFF);
         end else begin
            head = expQueue[0];
            checkOutput("dump_idx", 64'(dump_idx), 64'(head.idx));
            checkOutput("dump_data", 64'(dump_data), 64'(head.data));
            checkOutput("dump_last", 64'(dump_last), 64'(head.idx == ADDR_W'(DEPTH - 1)));
            if (readyV) begin
               void'(expQueue.pop_front());
               wordCount++;
            end
         end
      end else begin
         checkOutput("dump_last_idle", 64'(dump_last), 64'd0);
      end
   endtask

   // Called just after a falling edge: observe, drive one cycle of inputs, update the model.
   task automatic applyStimulus(input logic weV, input logic [ADDR_W-1:0] waV, input logic [DATA_W-1:0] wdV,
                                input logic startV, input logic readyV);
      dumpWord_t w;
      observeDump(readyV);
      we         = weV;
      wa         = waV;
      wd         = wdV;
      dump_start = startV;
      dump_ready = readyV;
      if (weV && waV != '0) begin
         model[waV] = wdV;
      end
      if (startV && !dump_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            w.idx  = ADDR_W'(i);
            w.data = model[i];
            expQueue.push_back(w);
         end
      end
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drainDump(input int expectCycles);
      cycleCount = 0;
      while (expQueue.size() > 0 && cycleCount < 200) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         nextCycle();
         cycleCount++;
      end
      checkOutput("dump_drained", 64'(expQueue.size()), 64'd0);
      checkOutput("dump_cycles", 64'(cycleCount), 64'(expectCycles));
      checkOutput("dump_valid_after", 64'(dump_valid), 64'd0);
   endtask

   task automatic runToIdx(input logic [ADDR_W-1:0] target);
      cycleCount = 0;
      while (dump_idx != target && cycleCount < 100) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         nextCycle();
         cycleCount++;
      end
      checkOutput("reach_idx", 64'(dump_idx), 64'(target));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      wordCount  = 0;
      rst_n      = 1'b1;
      ra1        = '0;
      ra2        = '0;
      we         = 1'b0;
      wa         = '0;
      wd         = '0;
      dump_start = 1'b0;
      dump_ready = 1'b0;
      resetModel();

      // Reset applied between clock edges, checked before any edge arrives.
      @(negedge clk);
      #1 rst_n = 1'b0;
      ra1 = 5'd5;
      ra2 = 5'd0;
      #1;
      checkOutput("reset_rd1_5", 64'(rd1), 64'd5);
      checkOutput("reset_rd2_0", 64'(rd2), 64'd0);
      checkOutput("reset_valid", 64'(dump_valid), 64'd0);
      ra1 = 5'd31;
      #1;
      checkOutput("reset_rd1_31", 64'(rd1), 64'd31);
      rst_n = 1'b1;
      @(negedge clk);

      // Write timing.
      ra1 = 5'd3;
      applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
      checkOutput("write_same_cycle", 64'(rd1), 64'hDEADBEEF);
`else
      checkOutput("write_same_cycle", 64'(rd1), 64'd3);
`endif
      nextCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("write_next_cycle", 64'(rd1), 64'hDEADBEEF);

      // Hardwired zero and dual-port same-address reads.
      ra1 = 5'd0;
      ra2 = 5'd3;
      applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
      checkOutput("zero_same_cycle", 64'(rd1), 64'd0);
      nextCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("zero_next_cycle", 64'(rd1), 64'd0);
      ra1 = 5'd3;
      #1;
      checkOutput("same_addr_rd1", 64'(rd1), 64'hDEADBEEF);
      checkOutput("same_addr_rd2", 64'(rd2), 64'hDEADBEEF);

      // Full dump, no backpressure: 32 words on consecutive cycles.
      nextCycle();
      wordCount = 0;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      checkOutput("dump_latency", 64'(dump_valid), 64'd1);
      drainDump(32);
      checkOutput("dump_words", 64'(wordCount), 64'd32);

      // Backpressure with a write to the held entry; snapshot must not change.
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      runToIdx(5'd4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd4, 32'hAAAA, 1'b0, 1'b0);
         nextCycle();
      end
      checkOutput("hold_idx", 64'(dump_idx), 64'd4);
      checkOutput("hold_data", 64'(dump_data), 64'd4);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      nextCycle();
      checkOutput("release_idx", 64'(dump_idx), 64'd5);
      drainDump(27);

      // Second dump sees the updated entries 3 and 4.
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      drainDump(32);

      // Level start held after completion relaunches a dump immediately.
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      runToIdx(5'd31);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      checkOutput("complete_valid", 64'(dump_valid), 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      checkOutput("restart_valid", 64'(dump_valid), 64'd1);
      checkOutput("restart_idx", 64'(dump_idx), 64'd0);

      // Mid-dump asynchronous reset.
      runToIdx(5'd10);
      #1 rst_n = 1'b0;
      ra1 = 5'd3;
      ra2 = 5'd4;
      #1;
      checkOutput("abort_valid", 64'(dump_valid), 64'd0);
      checkOutput("abort_idx", 64'(dump_idx), 64'd0);
      checkOutput("abort_data", 64'(dump_data), 64'd0);
      checkOutput("abort_rd1", 64'(rd1), 64'd3);
      checkOutput("abort_rd2", 64'(rd2), 64'd4);
      expQueue.delete();
      resetModel();
      dump_start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Start pulse during a stream is ignored: exactly 32 words.
      wordCount = 0;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      runToIdx(5'd3);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
      nextCycle();
      drainDump(28);
      checkOutput("restart_words", 64'(wordCount), 64'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
